operand_fifo8: RTL and testbench
================================

OPERAND_FIFO8 -- requirements
Module: operand_fifo8

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of storage entries (power of two).
REQ-003 Port CLK SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port RST SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port WR_EN SHALL be an input, 1 bit: the producer pushes WR_DATA this cycle.
REQ-006 Port WR_DATA SHALL be an input, WIDTH bits: the operand to enqueue.
REQ-007 Port FULL SHALL be an output, 1 bit: asserted when COUNT == DEPTH.
REQ-008 Port RD_EN SHALL be an input, 1 bit: the accumulator consumes the head word this cycle.
REQ-009 Port RD_DATA SHALL be an output, WIDTH bits: the head word in first-word fall-through mode, driving the accumulator's A operand.
REQ-010 Port EMPTY SHALL be an output, 1 bit: asserted when COUNT == 0.
REQ-011 Port COUNT SHALL be an output, log2(DEPTH)+1 bits: the number of stored words.
REQ-012 Port OVERFLOW SHALL be an output, 1 bit: sticky flag for a rejected write.
REQ-013 Port UNDERFLOW SHALL be an output, 1 bit: sticky flag for a rejected read.

Function
REQ-014 A write SHALL be accepted when WR_EN=1 and (FULL=0 or RD_EN=1); the word goes to the tail, and the write pointer increments modulo DEPTH.
REQ-015 A read SHALL be accepted when RD_EN=1 and EMPTY=0; the read pointer increments modulo DEPTH.
REQ-016 RD_DATA SHALL equal the word at the read pointer whenever EMPTY=0, and SHALL be all-zero whenever EMPTY=1, so a downstream adder adds 0 when starved.
REQ-017 COUNT SHALL increment on an accepted write only, decrement on an accepted read only, and hold when both or neither are accepted.
REQ-018 On full with WR_EN=1 and RD_EN=1, both SHALL be accepted: the head is read, the new word is stored in the freed slot, and COUNT stays DEPTH.
REQ-019 On empty with WR_EN=1 and RD_EN=1, the read SHALL be rejected (UNDERFLOW set) and the write accepted; RD_DATA shows the new word the next cycle.
REQ-020 On full with WR_EN=1 and RD_EN=0, the write SHALL be dropped, storage SHALL be unchanged, and OVERFLOW SHALL be set.
REQ-021 On empty with RD_EN=1, the pointers SHALL be unchanged and UNDERFLOW SHALL be set.
REQ-022 OVERFLOW and UNDERFLOW SHALL remain set until reset.
REQ-023 Pointer wrap-around SHALL be seamless: ordering is preserved across any number of wraps.
REQ-024 FULL, EMPTY and COUNT SHALL be registered-state-derived, with no combinational path from WR_EN/RD_EN.
REQ-025 Write-to-RD_DATA latency SHALL be one cycle when empty.

Reset
REQ-026 When RST=0, the pointers and COUNT SHALL go to 0, EMPTY to 1, FULL to 0, OVERFLOW and UNDERFLOW to 0, and RD_DATA to 0, without waiting for CLK.
REQ-027 Storage contents SHALL be cleared to 0 on reset.
REQ-028 Reset mid-operation SHALL discard all queued words; the first edge after RST returns to 1 behaves as from empty.
REQ-029 Deassertion of RST SHALL be assumed synchronous to CLK by the integrator.

Structure
REQ-030 WIDTH, DEPTH and the pointer width constant SHALL live in a shared package/header, fifo_defs, which is reused by the accumulator.
REQ-031 Storage SHALL be one sub-module, fifo_mem (DEPTH x WIDTH flip-flop array, one write port, one asynchronous read port); the pointer, count and flag logic stays in operand_fifo8.
REQ-032 The block SHALL connect to the accumulator as RD_DATA to A, and SHALL assert RD_EN each cycle the accumulator registers a sum.

Verification
REQ-033 Reset: hold RST=0 for 350 ns, then release -> EMPTY=1, FULL=0, COUNT=0, RD_DATA=8'h00, flags=0.
REQ-034 Fill/drain: write 8'h01, 8'h02, 8'h04, 8'h08 -> FULL=1, COUNT=4; then read four times -> RD_DATA sequence 01, 02, 04, 08, ending EMPTY=1.
REQ-035 Overflow: on full, write 8'h10 with RD_EN=0 -> OVERFLOW=1, COUNT=4, and the subsequent drain yields no 8'h10.
REQ-036 Simultaneous on full: WR 8'h20 + RD -> COUNT=4; drain order is 02, 04, 08, 20.
REQ-037 Empty read and wrap: RD_EN on empty -> UNDERFLOW=1, RD_DATA=00; then 10 write/read pairs of values 0..9 -> each read equals the write value in order, across the pointer wrap.
REQ-038 Mid-operation reset: with 3 words queued, pulse RST=0 for 100 ns -> COUNT=0, flags cleared; the next write 8'h03 then appears on RD_DATA one cycle later.

Source files
------------

// File: rtl/fifo_defs.sv
// Shared operand-FIFO sizing constants, also used by the accumulator.
package fifo_defs;

   localparam int unsigned FIFO_WIDTH = 8;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

   typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage : fifo_defs

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH flip-flop storage: one synchronous write port, one asynchronous read port.
module fifo_mem
   import fifo_defs::*;
#(
   parameter int unsigned WIDTH  = FIFO_WIDTH,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; contents cleared on reset so stale words never reappear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read of the addressed entry (first-word fall-through).
   always_comb begin
      rdata = mem[raddr];
   end

endmodule : fifo_mem

// File: rtl/operand_fifo8.sv
// First-word fall-through operand FIFO feeding the accumulator A operand.
module operand_fifo8
   import fifo_defs::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] head_c;
   logic             wr_ok_c;
   logic             rd_ok_c;

   // Accept decisions; a write on full is allowed only when the head leaves the same cycle.
   always_comb begin
      wr_ok_c = wr_en && (!full || rd_en);
      rd_ok_c = rd_en && !empty;
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok_c) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (rd_ok_c) begin
            rptr <= rptr + PTR_W'(1);
         end
         case ({wr_ok_c, rd_ok_c})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (wr_en && !wr_ok_c) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_ok_c) begin
            underflow <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst),
      .we    (wr_ok_c),
      .waddr (wptr),
      .wdata (wr_data),
      .raddr (rptr),
      .rdata (head_c)
   );

   // Status and head word derive only from registered state; a starved reader sees zero.
   always_comb begin
      count   = cnt;
      full    = (cnt == CNT_W'(DEPTH));
      empty   = (cnt == '0);
      rd_data = empty ? '0 : head_c;
   end

endmodule : operand_fifo8

// File: tb/tb_operand_fifo8.sv
// Self-checking bench for operand_fifo8 against a queue-based reference model.
module tb_operand_fifo8;

   localparam int unsigned DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   operand_fifo8 #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: FIFO semantics from the queue contents.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         bit wa, ra;
         ra = rd_en && (mq.size() > 0);
         wa = wr_en && ((mq.size() < DEPTH) || rd_en);
         if (wr_en && !wa) m_ovf = 1'b1;
         if (rd_en && !ra) m_unf = 1'b1;
         if (ra) void'(mq.pop_front());
         if (wa) mq.push_back(wr_data);
      end
   end

   // Compare DUT against model every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] exp_rd;
      exp_rd = (mq.size() > 0) ? mq[0] : 8'h00;
      chk("cmp_rd_data",   32'(rd_data),   32'(exp_rd));
      chk("cmp_count",     32'(count),     32'(mq.size()));
      chk("cmp_empty",     32'(empty),     32'(mq.size() == 0));
      chk("cmp_full",      32'(full),      32'(mq.size() == DEPTH));
      chk("cmp_overflow",  32'(overflow),  32'(m_ovf));
      chk("cmp_underflow", 32'(underflow), 32'(m_unf));
   end

   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      @(posedge clk);
      #2;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] fill_v [4];
      logic [7:0] drain_v [4];
      fill_v  = '{8'h01, 8'h02, 8'h04, 8'h08};
      drain_v = '{8'h02, 8'h04, 8'h08, 8'h20};
      rst     = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = 8'h00;

      // Reset state
      #350;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'h00);
      chk("rst_flags", 32'({overflow, underflow}), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;

      // Fill then drain
      for (int i = 0; i < 4; i++) cyc(1'b1, fill_v[i], 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", 32'(rd_data), 32'(fill_v[i]));
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Overflow on full, then simultaneous read+write on full
      for (int i = 0; i < 4; i++) cyc(1'b1, fill_v[i], 1'b0);
      cyc(1'b1, 8'h10, 1'b0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      cyc(1'b1, 8'h20, 1'b1);
      chk("sim_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("sim_drain", 32'(rd_data), 32'(drain_v[i]));
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("sim_empty", 32'(empty), 32'd1);

      // Empty read
      cyc(1'b0, 8'h00, 1'b1);
      chk("unf_flag", 32'(underflow), 32'd1);
      chk("unf_rd_data", 32'(rd_data), 32'h00);

      // Read+write on empty: write accepted, data visible next cycle
      cyc(1'b1, 8'h55, 1'b1);
      chk("empty_rw_data", 32'(rd_data), 32'h55);
      chk("empty_rw_count", 32'(count), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);

      // Ten write/read pairs across pointer wraps
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         chk("wrap_data", 32'(rd_data), 32'(i));
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // Mid-operation reset with three words queued
      cyc(1'b1, 8'hA1, 1'b0);
      cyc(1'b1, 8'hB2, 1'b0);
      cyc(1'b1, 8'hC3, 1'b0);
      chk("mid_pre_count", 32'(count), 32'd3);
      rst = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_rd_data", 32'(rd_data), 32'h00);
      chk("mid_rst_flags", 32'({overflow, underflow}), 32'd0);
      #99 rst = 1'b1;
      cyc(1'b1, 8'h03, 1'b0);
      chk("mid_after_data", 32'(rd_data), 32'h03);
      chk("mid_after_count", 32'(count), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_operand_fifo8
